// File: rtl/rv_decode_pkg.sv
// Shared RV32I/RV32E decode constants: opcodes, one-hot-index operation codes and
// immediate formats used by id_decode_comb and id_stage.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] OH_NOP   = 7'd0;
  localparam logic [6:0] OH_LUI   = 7'd1;
  localparam logic [6:0] OH_AUIPC = 7'd2;
  localparam logic [6:0] OH_JAL   = 7'd3;
  localparam logic [6:0] OH_JALR  = 7'd4;
  localparam logic [6:0] OH_BEQ   = 7'd5;
  localparam logic [6:0] OH_BNE   = 7'd6;
  localparam logic [6:0] OH_BLT   = 7'd7;
  localparam logic [6:0] OH_BGE   = 7'd8;
  localparam logic [6:0] OH_BLTU  = 7'd9;
  localparam logic [6:0] OH_BGEU  = 7'd10;
  localparam logic [6:0] OH_LB    = 7'd11;
  localparam logic [6:0] OH_LH    = 7'd12;
  localparam logic [6:0] OH_LW    = 7'd13;
  localparam logic [6:0] OH_LBU   = 7'd14;
  localparam logic [6:0] OH_LHU   = 7'd15;
  localparam logic [6:0] OH_ADDI  = 7'd19;
  localparam logic [6:0] OH_SLTI  = 7'd20;
  localparam logic [6:0] OH_SLTIU = 7'd21;
  localparam logic [6:0] OH_XORI  = 7'd22;
  localparam logic [6:0] OH_ORI   = 7'd23;
  localparam logic [6:0] OH_ANDI  = 7'd24;
  localparam logic [6:0] OH_SLLI  = 7'd25;
  localparam logic [6:0] OH_SRLI  = 7'd26;
  localparam logic [6:0] OH_SRAI  = 7'd27;
  localparam logic [6:0] OH_ADD   = 7'd28;
  localparam logic [6:0] OH_SUB   = 7'd29;
  localparam logic [6:0] OH_SLL   = 7'd30;
  localparam logic [6:0] OH_SLT   = 7'd31;
  localparam logic [6:0] OH_SLTU  = 7'd32;
  localparam logic [6:0] OH_XOR   = 7'd33;
  localparam logic [6:0] OH_SRL   = 7'd34;
  localparam logic [6:0] OH_SRA   = 7'd35;
  localparam logic [6:0] OH_OR    = 7'd36;
  localparam logic [6:0] OH_AND   = 7'd37;
  localparam logic [6:0] OH_SB    = 7'd38;
  localparam logic [6:0] OH_SH    = 7'd39;
  localparam logic [6:0] OH_SW    = 7'd40;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;

  function automatic logic is_load_oh(input logic [6:0] oh);
    return (oh >= OH_LB) && (oh <= OH_LHU);
  endfunction

  function automatic logic is_shift_imm_oh(input logic [6:0] oh);
    return (oh >= OH_SLLI) && (oh <= OH_SRAI);
  endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational RV32I/RV32E instruction decoder: operation code, immediate
// format, register fields, source usage and the illegal-instruction indication.
module id_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic [31:0]     i_ins,
  output logic [6:0]      o_oh,
  output imm_fmt_e        o_fmt,
  output logic [AW-1:0]   o_rs1,
  output logic [AW-1:0]   o_rs2,
  output logic [AW-1:0]   o_rd,
  output logic            o_uses_rs1,
  output logic            o_uses_rs2,
  output logic            o_wr_rd,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_bad_reg;
  logic [31:0] w_imm32;

  assign w_opc = i_ins[6:0];
  assign w_f3  = i_ins[14:12];
  assign w_f7  = i_ins[31:25];

  always_comb begin
    o_oh       = OH_NOP;
    o_fmt      = IMM_NONE;
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    o_wr_rd    = 1'b0;
    w_bad_reg  = 1'b0;
    o_illegal  = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        o_oh = OH_LUI; o_fmt = IMM_U; o_wr_rd = 1'b1;
      end
      OPC_AUIPC: begin
        o_oh = OH_AUIPC; o_fmt = IMM_U; o_wr_rd = 1'b1;
      end
      OPC_JAL: begin
        o_oh = OH_JAL; o_fmt = IMM_J; o_wr_rd = 1'b1;
      end
      OPC_JALR: begin
        if (w_f3 == 3'b000) o_oh = OH_JALR;
        o_fmt = IMM_I; o_uses_rs1 = 1'b1; o_wr_rd = 1'b1;
      end
      OPC_BRANCH: begin
        case (w_f3)
          3'b000:  o_oh = OH_BEQ;
          3'b001:  o_oh = OH_BNE;
          3'b100:  o_oh = OH_BLT;
          3'b101:  o_oh = OH_BGE;
          3'b110:  o_oh = OH_BLTU;
          3'b111:  o_oh = OH_BGEU;
          default: o_oh = OH_NOP;
        endcase
        o_fmt = IMM_B; o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        case (w_f3)
          3'b000:  o_oh = OH_LB;
          3'b001:  o_oh = OH_LH;
          3'b010:  o_oh = OH_LW;
          3'b100:  o_oh = OH_LBU;
          3'b101:  o_oh = OH_LHU;
          default: o_oh = OH_NOP;
        endcase
        o_fmt = IMM_I; o_uses_rs1 = 1'b1; o_wr_rd = 1'b1;
      end
      OPC_STORE: begin
        case (w_f3)
          3'b000:  o_oh = OH_SB;
          3'b001:  o_oh = OH_SH;
          3'b010:  o_oh = OH_SW;
          default: o_oh = OH_NOP;
        endcase
        o_fmt = IMM_S; o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        case (w_f3)
          3'b000: o_oh = OH_ADDI;
          3'b010: o_oh = OH_SLTI;
          3'b011: o_oh = OH_SLTIU;
          3'b100: o_oh = OH_XORI;
          3'b110: o_oh = OH_ORI;
          3'b111: o_oh = OH_ANDI;
          3'b001: if (w_f7 == 7'b0000000) o_oh = OH_SLLI;
          default: begin
            if (w_f7 == 7'b0000000)      o_oh = OH_SRLI;
            else if (w_f7 == 7'b0100000) o_oh = OH_SRAI;
          end
        endcase
        o_fmt = IMM_I; o_uses_rs1 = 1'b1; o_wr_rd = 1'b1;
      end
      OPC_OP: begin
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  o_oh = OH_ADD;
            3'b001:  o_oh = OH_SLL;
            3'b010:  o_oh = OH_SLT;
            3'b011:  o_oh = OH_SLTU;
            3'b100:  o_oh = OH_XOR;
            3'b101:  o_oh = OH_SRL;
            3'b110:  o_oh = OH_OR;
            default: o_oh = OH_AND;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      o_oh = OH_SUB;
          else if (w_f3 == 3'b101) o_oh = OH_SRA;
        end
        o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; o_wr_rd = 1'b1;
      end
      default: ;
    endcase
    // RV32E has only x0..x15: a used register field with bit 4 set cannot be encoded
    if (NREG == 16)
      w_bad_reg = (o_uses_rs1 && i_ins[19]) || (o_uses_rs2 && i_ins[24]) || (o_wr_rd && i_ins[11]);
    o_illegal = (o_oh == OH_NOP) || w_bad_reg;
    if (o_illegal) begin
      o_oh       = OH_NOP;
      o_fmt      = IMM_NONE;
      o_uses_rs1 = 1'b0;
      o_uses_rs2 = 1'b0;
      o_wr_rd    = 1'b0;
    end
  end

  always_comb begin
    case (o_fmt)
      IMM_I:   w_imm32 = {{20{i_ins[31]}}, i_ins[31:20]};
      IMM_S:   w_imm32 = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
      IMM_B:   w_imm32 = {{19{i_ins[31]}}, i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
      IMM_U:   w_imm32 = {i_ins[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{i_ins[31]}}, i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'(signed'(w_imm32));
  assign o_rs1 = o_uses_rs1 ? i_ins[15 +: AW] : '0;
  assign o_rs2 = o_uses_rs2 ? i_ins[20 +: AW] : '0;
  assign o_rd  = o_wr_rd    ? i_ins[7 +: AW]  : '0;

endmodule

// File: rtl/id_stage.sv
// Registered, handshaked RV32I/RV32E decode stage with load-use interlock and flush.
// Define ID_ILLEGAL_FLAG_EN to register the illegal-instruction flag; otherwise it reads 0.
module id_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  output logic [AW-1:0]   rs1_addr,
  output logic [AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ins,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] imm,
  output logic [AW-1:0]   rd_addr,
  output logic            rd_wen,
  output logic [6:0]      oh,
  output logic            illegal
);

  logic [6:0]      w_oh;
  imm_fmt_e        w_fmt;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic [AW-1:0]   w_rd;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_wr_rd;
  logic [XLEN-1:0] w_imm;
  logic            w_dec_illegal;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_rd_wen;
  logic            w_hazard;
  logic            w_accept;

  logic            r_out_valid;
  logic [31:0]     r_ins;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_imm;
  logic [AW-1:0]   r_rd;
  logic            r_rd_wen;
  logic [6:0]      r_oh;

  id_decode_comb #(.XLEN(XLEN), .NREG(NREG)) u_decode (
    .i_ins      (in_ins),
    .o_oh       (w_oh),
    .o_fmt      (w_fmt),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_rd       (w_rd),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_wr_rd    (w_wr_rd),
    .o_imm      (w_imm),
    .o_illegal  (w_dec_illegal)
  );

  assign rs1_addr = w_rs1;
  assign rs2_addr = w_rs2;

  // Handshake: a beat transfers on an edge where valid && ready on that side. Output
  // side holds everything stable while out_valid && !out_ready; in_ready never depends
  // on in_valid. A load result still in the output register blocks a dependent reader.
  assign w_hazard = r_out_valid && is_load_oh(r_oh) && (r_rd != '0) &&
                    ((w_uses_rs1 && (w_rs1 == r_rd)) || (w_uses_rs2 && (w_rs2 == r_rd)));
  assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_rd_wen = w_wr_rd && (w_rd != '0) && !w_dec_illegal;

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    if (w_oh == OH_LUI) begin
      w_op1 = w_imm;
    end else if (w_oh == OH_AUIPC) begin
      w_op1 = in_pc;
      w_op2 = w_imm;
    end else if (w_oh == OH_JAL) begin
      w_op1 = in_pc;
      w_op2 = XLEN'(32'd4);
    end else if (is_shift_imm_oh(w_oh)) begin
      w_op1 = rs1_data;
      w_op2 = XLEN'(in_ins[24:20]);
    end else if (w_uses_rs2) begin
      w_op1 = rs1_data;
      w_op2 = rs2_data;
    end else if (w_uses_rs1) begin
      w_op1 = rs1_data;
      w_op2 = w_imm;
    end
  end

  // Flush, an empty/consumed slot with no accept, and reset all leave a zeroed bubble
  always_ff @(posedge clk) begin
    if (rst || flush || (!w_accept && out_ready)) begin
      r_out_valid <= 1'b0;
      r_ins       <= '0;
      r_pc        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_rd_wen    <= 1'b0;
      r_oh        <= OH_NOP;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_ins       <= in_ins;
      r_pc        <= in_pc;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_imm       <= w_imm;
      r_rd        <= w_rd;
      r_rd_wen    <= w_rd_wen;
      r_oh        <= w_oh;
    end
  end

`ifdef ID_ILLEGAL_FLAG_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (rst || flush || (!w_accept && out_ready)) r_illegal <= 1'b0;
    else if (w_accept)                            r_illegal <= w_dec_illegal;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign out_ins   = r_ins;
  assign out_pc    = r_pc;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign imm       = r_imm;
  assign rd_addr   = r_rd;
  assign rd_wen    = r_rd_wen;
  assign oh        = r_oh;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: scoreboard queue filled on accepted beats, monitor pops on
// consumed outputs; a second RV32E instance covers the illegal register check.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [6:0]  oh;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

`ifdef ID_ILLEGAL_FLAG_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  localparam logic [31:0] I_ADDI = 32'hFFD08293; // addi x5,x1,-3
  localparam logic [31:0] I_LUI  = 32'h12345337; // lui x6,0x12345
  localparam logic [31:0] I_AUI  = 32'h00001417; // auipc x8,1
  localparam logic [31:0] I_JAL  = 32'h008000EF; // jal x1,+8
  localparam logic [31:0] I_JALR = 32'h004280E7; // jalr x1,4(x5)
  localparam logic [31:0] I_SRAI = 32'h4030D493; // srai x9,x1,3
  localparam logic [31:0] I_SUB0 = 32'h40208033; // sub x0,x1,x2
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
  localparam logic [31:0] I_LW   = 32'h00012183; // lw x3,0(x2)
  localparam logic [31:0] I_ADD  = 32'h00118233; // add x4,x3,x1
  localparam logic [31:0] I_SW   = 32'h00712423; // sw x7,8(x2)
  localparam logic [31:0] I_BEQ  = 32'h00208863; // beq x1,x2,+16
  localparam logic [31:0] I_AD17 = 32'h002088B3; // add x17,x1,x2
  localparam logic [31:0] I_AD4  = 32'h00208233; // add x4,x1,x2

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready, rd_wen, illegal;
  logic [31:0] in_ins, in_pc, rs1_data, rs2_data, out_ins, out_pc, op1, op2, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [6:0]  oh;
  logic [31:0] rf [32];

  logic        e_in_valid, e_in_ready, e_out_valid, e_rd_wen, e_illegal;
  logic [31:0] e_in_ins, e_out_ins, e_out_pc, e_op1, e_op2, e_imm;
  logic [3:0]  e_rs1_addr, e_rs2_addr, e_rd_addr;
  logic [6:0]  e_oh;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   waits;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  id_stage #(.XLEN(32), .NREG(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
    .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_pc(out_pc), .op1(op1), .op2(op2), .imm(imm),
    .rd_addr(rd_addr), .rd_wen(rd_wen), .oh(oh), .illegal(illegal)
  );

  id_stage #(.XLEN(32), .NREG(16)) u_dut_e (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_ins(e_in_ins),
    .in_pc(32'h0), .rs1_addr(e_rs1_addr), .rs2_addr(e_rs2_addr), .rs1_data(32'h11),
    .rs2_data(32'h22), .flush(1'b0), .out_valid(e_out_valid), .out_ready(1'b1),
    .out_ins(e_out_ins), .out_pc(e_out_pc), .op1(e_op1), .op2(e_op2), .imm(e_imm),
    .rd_addr(e_rd_addr), .rd_wen(e_rd_wen), .oh(e_oh), .illegal(e_illegal)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] i, input logic [4:0] rd, input logic w,
                              input logic il);
    exp_t e;
    e.ins = '0; e.pc = '0; e.op1 = a; e.op2 = b; e.imm = i;
    e.oh = o; e.rd = rd; e.wen = w; e.ill = il;
    return e;
  endfunction

  // driver: present a beat until accepted, queue the expected result at acceptance
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e,
                      output int nwait);
    bit done = 0;
    in_ins = ins; in_pc = pc; in_valid = 1'b1; nwait = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.ins = ins; e.pc = pc;
        exp_q.push_back(e);
        done = 1;
      end else begin
        nwait++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: ins %h never accepted", ins);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got ins %h with nothing expected", out_ins);
      end else begin
        e = exp_q.pop_front();
        check("out_ins", out_ins, e.ins);
        check("out_pc", out_pc, e.pc);
        check("oh", 32'(oh), 32'(e.oh));
        check("op1", op1, e.op1);
        check("op2", op2, e.op2);
        check("imm", imm, e.imm);
        check("rd_addr", 32'(rd_addr), 32'(e.rd));
        check("rd_wen", 32'(rd_wen), 32'(e.wen));
        check("illegal", 32'(illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'h0;
    rf[1] = 32'd10;
    rst = 1'b1; in_valid = 1'b1; in_ins = I_ADDI; in_pc = 32'h0; flush = 1'b0; out_ready = 1'b1;
    e_in_valid = 1'b0; e_in_ins = 32'h0;

    repeat (2) begin
      @(posedge clk); #1;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_oh", 32'(oh), 32'h0);
      check("rst_op1", op1, 32'h0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(out_valid), 32'h0);
    check("post_rst_oh", 32'(oh), 32'h0);
    check("post_rst_op1", op1, 32'h0);

    in_ins = I_ADDI; #1;
    check("addi_rs1_addr", 32'(rs1_addr), 32'd1);
    check("addi_rs2_addr", 32'(rs2_addr), 32'd0);
    send(I_ADDI, 32'h000, mk(7'd19, 32'd10, 32'hFFFFFFFD, 32'hFFFFFFFD, 5'd5, 1'b1, 1'b0), waits);
    send(I_LUI,  32'h004, mk(7'd1, 32'h12345000, 32'h0, 32'h12345000, 5'd6, 1'b1, 1'b0), waits);
    send(I_AUI,  32'h100, mk(7'd2, 32'h100, 32'h1000, 32'h1000, 5'd8, 1'b1, 1'b0), waits);
    send(I_JAL,  32'h200, mk(7'd3, 32'h200, 32'h4, 32'h8, 5'd1, 1'b1, 1'b0), waits);
    send(I_JALR, 32'h204, mk(7'd4, 32'h1005, 32'h4, 32'h4, 5'd1, 1'b1, 1'b0), waits);
    send(I_SRAI, 32'h208, mk(7'd27, 32'd10, 32'd3, 32'h403, 5'd9, 1'b1, 1'b0), waits);
    send(I_SUB0, 32'h20C, mk(7'd29, 32'd10, 32'h1002, 32'h0, 5'd0, 1'b0, 1'b0), waits);

    in_ins = I_BAD; #1;
    check("bad_rs1_addr", 32'(rs1_addr), 32'd0);
    check("bad_rs2_addr", 32'(rs2_addr), 32'd0);
    send(I_BAD, 32'h210, mk(7'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, ILL_EXP), waits);

    // load-use: one bubble, then fresh x3
    send(I_LW, 32'h300, mk(7'd13, 32'h1002, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0), waits);
    check("lw_no_stall", 32'(waits), 32'd0);
    rf[3] = 32'd77;
    send(I_ADD, 32'h304, mk(7'd28, 32'd77, 32'd10, 32'h0, 5'd4, 1'b1, 1'b0), waits);
    check("load_use_stall", 32'(waits), 32'd1);
    send(I_LW, 32'h308, mk(7'd13, 32'h1002, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0), waits);
    send(I_ADDI, 32'h30C, mk(7'd19, 32'd10, 32'hFFFFFFFD, 32'hFFFFFFFD, 5'd5, 1'b1, 1'b0), waits);
    check("load_indep_stall", 32'(waits), 32'd0);

    // backpressure on a store
    send(I_SW, 32'h400, mk(7'd40, 32'h1002, 32'h1007, 32'h8, 5'd0, 1'b0, 1'b0), waits);
    out_ready = 1'b0; in_valid = 1'b1; in_ins = I_ADDI; in_pc = 32'h404;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'h1);
      check("hold_oh", 32'(oh), 32'd40);
      check("hold_imm", imm, 32'h8);
      check("hold_op2", op2, 32'h1007);
      check("hold_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(I_ADDI, 32'h404, mk(7'd19, 32'd10, 32'hFFFFFFFD, 32'hFFFFFFFD, 5'd5, 1'b1, 1'b0), waits);

    // flush kills the held LUI and the incoming BEQ
    send(I_LUI, 32'h500, mk(7'd1, 32'h12345000, 32'h0, 32'h12345000, 5'd6, 1'b1, 1'b0), waits);
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_ins = I_BEQ; in_pc = 32'h504;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'h0);
    check("flush_oh", 32'(oh), 32'h0);
    if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    out_ready = 1'b1;
    send(I_BEQ, 32'h504, mk(7'd5, 32'd10, 32'h1002, 32'd16, 5'd0, 1'b0, 1'b0), waits);

    // RV32E instance
    e_in_ins = I_AD17; e_in_valid = 1'b1;
    @(posedge clk); #1;
    check("e_x17_out_valid", 32'(e_out_valid), 32'h1);
    check("e_x17_illegal", 32'(e_illegal), 32'(ILL_EXP));
    check("e_x17_oh", 32'(e_oh), 32'h0);
    check("e_x17_rd_wen", 32'(e_rd_wen), 32'h0);
    e_in_ins = I_AD4;
    @(posedge clk); #1;
    e_in_valid = 1'b0;
    check("e_x4_oh", 32'(e_oh), 32'd28);
    check("e_x4_rd", 32'(e_rd_addr), 32'd4);
    check("e_x4_op1", e_op1, 32'h11);
    check("e_x4_op2", e_op2, 32'h22);
    check("e_x4_illegal", 32'(e_illegal), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
